snitch_icache_data_ctrl: RTL and testbench

- Initiator side of the icache data memory. It arbitrates refill writes against lookup reads into the per-set line SRAMs.
- Issues one SRAM access per cycle, captures read data one cycle after issue, and buffers it in a 2-entry response FIFO so downstream backpressure never loses a line.
- Sits between the lookup/refill logic and the data-array macro wrapper.

---
 rtl/snitch_icache_pkg.sv | 20 ++
 rtl/snitch_icache_data_ctrl_if.sv | 58 +++++
 rtl/snitch_icache_data_rsp_fifo.sv | 67 ++++++
 rtl/snitch_icache_data_ctrl.sv | 167 ++++++++++++++++
 tb/tb_snitch_icache_data_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared icache package: data-array line, address and way types.
// Holds the response buffer depth used by the data controller.
package snitch_icache_pkg;

  localparam int unsigned DataSetCount  = 2;
  localparam int unsigned DataLineWidth = 128;
  localparam int unsigned DataLineCount = 128;
  localparam int unsigned DataRspDepth  = 2;
  localparam int unsigned DataRspCntW   = $clog2(DataRspDepth + 1);

  // Way index width never collapses to zero bits.
  function automatic int unsigned set_align(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [DataLineWidth-1:0]              data_line_t;
  typedef logic [$clog2(DataLineCount)-1:0]      data_addr_t;
  typedef logic [set_align(DataSetCount)-1:0]    data_set_t;

endpackage

// File: rtl/snitch_icache_data_ctrl_if.sv
// Bundle of lookup, refill, response and SRAM signals of the
// icache data controller; slave is the controller side.
interface snitch_icache_data_ctrl_if
  import snitch_icache_pkg::*;
#(
  parameter int unsigned SET_COUNT   = DataSetCount,
  parameter int unsigned LINE_WIDTH  = DataLineWidth,
  parameter int unsigned LINE_COUNT  = DataLineCount,
  parameter int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN   = set_align(SET_COUNT)
);

  logic                          lookup_valid_i;
  logic [COUNT_ALIGN-1:0]        lookup_addr_i;
  logic [SET_ALIGN-1:0]          lookup_set_i;
  logic                          lookup_ready_o;

  logic                          rsp_valid_o;
  logic [LINE_WIDTH-1:0]         rsp_data_o;
  logic                          rsp_ready_i;

  logic                          refill_valid_i;
  logic [COUNT_ALIGN-1:0]        refill_addr_i;
  logic [SET_ALIGN-1:0]          refill_set_i;
  logic [LINE_WIDTH-1:0]         refill_data_i;
  logic                          refill_ready_o;

  logic [SET_COUNT-1:0]          ram_enable_o;
  logic                          ram_write_o;
  logic [COUNT_ALIGN-1:0]        ram_addr_o;
  logic [SET_COUNT*LINE_WIDTH-1:0] ram_wdata_o;
  logic [SET_COUNT*LINE_WIDTH-1:0] ram_rdata_i;

  modport slave (
    input  lookup_valid_i, lookup_addr_i, lookup_set_i,
    output lookup_ready_o,
    output rsp_valid_o, rsp_data_o,
    input  rsp_ready_i,
    input  refill_valid_i, refill_addr_i, refill_set_i,
    input  refill_data_i,
    output refill_ready_o,
    output ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output lookup_valid_i, lookup_addr_i, lookup_set_i,
    input  lookup_ready_o,
    input  rsp_valid_o, rsp_data_o,
    output rsp_ready_i,
    output refill_valid_i, refill_addr_i, refill_set_i,
    output refill_data_i,
    input  refill_ready_o,
    input  ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/snitch_icache_data_rsp_fifo.sv
// Two-entry fall-through line buffer for captured read data.
// An empty buffer forwards the pushed line in the same cycle.
module snitch_icache_data_rsp_fifo
  import snitch_icache_pkg::*;
#(
  parameter int unsigned WIDTH = DataLineWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [DataRspCntW-1:0] count_o
);

  localparam logic [DataRspCntW-1:0] Full =
    DataRspCntW'(DataRspDepth);

  logic [WIDTH-1:0]       mem_q [DataRspDepth];
  logic                   wptr_q;
  logic                   rptr_q;
  logic [DataRspCntW-1:0] count_q;
  logic                   empty;
  logic                   bypass;
  logic                   store;
  logic                   take;

  assign empty   = (count_q == '0);
  assign bypass  = empty && push_i && pop_i;
  assign store   = push_i && !bypass && (count_q != Full);
  assign take    = pop_i && !empty;
  assign valid_o = !empty || push_i;
  assign data_o  = empty ? push_data_i : mem_q[rptr_q];
  assign count_o = count_q;

  // Line storage, written only when the line is not bypassed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (store) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  // Pointers and saturating occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (store) wptr_q <= !wptr_q;
      if (take)  rptr_q <= !rptr_q;
      unique case ({store, take})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      assert (!(push_i && (count_q == Full)));
      assert (count_q <= Full);
    end
  end

endmodule

// File: rtl/snitch_icache_data_ctrl.sv
// Icache data-array initiator: refill/lookup arbitration, credit-gated
// reads, response buffering. Option: SNITCH_ICACHE_DATA_CTRL_STARVE_GUARD_EN.
module snitch_icache_data_ctrl
  import snitch_icache_pkg::*;
#(
  parameter int unsigned SET_COUNT    = DataSetCount,
  parameter int unsigned LINE_WIDTH   = DataLineWidth,
  parameter int unsigned LINE_COUNT   = DataLineCount,
  parameter int unsigned COUNT_ALIGN  = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN    = set_align(SET_COUNT),
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  snitch_icache_data_ctrl_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [DataRspCntW-1:0] fifo_count;
  logic                   inflight_q;
  logic [SET_ALIGN-1:0]   set_q;
  logic [COUNT_ALIGN-1:0] addr_q;
  logic                   write_q;
  logic                   credit_ok;
  logic                   guard_fire;
  logic                   refill_ready;
  logic                   refill_fire;
  logic                   lookup_ready;
  logic                   lookup_fire;
  logic [SET_COUNT-1:0]   ram_enable;
  logic                   ram_write;
  logic [COUNT_ALIGN-1:0] ram_addr;
  logic [LINE_WIDTH-1:0]  rd_line;

  // A read needs a guaranteed slot for its line one cycle later.
  assign credit_ok =
    ({1'b0, fifo_count} + {{DataRspCntW{1'b0}}, inflight_q})
    < (DataRspCntW+1)'(DataRspDepth);

  assign refill_ready = !guard_fire;
  assign refill_fire  = bus.refill_valid_i && refill_ready;
  assign lookup_ready = credit_ok && !refill_fire;
  assign lookup_fire  = bus.lookup_valid_i && lookup_ready;

  assign bus.refill_ready_o = refill_ready;
  assign bus.lookup_ready_o = lookup_ready;

  // SRAM command; address and direction hold while idle
  always_comb begin
    ram_enable = '0;
    ram_write  = write_q;
    ram_addr   = addr_q;
    unique case (1'b1)
      refill_fire: begin
        ram_enable = SET_COUNT'(1) << bus.refill_set_i;
        ram_write  = 1'b1;
        ram_addr   = bus.refill_addr_i;
      end
      lookup_fire: begin
        ram_enable = SET_COUNT'(1) << bus.lookup_set_i;
        ram_write  = 1'b0;
        ram_addr   = bus.lookup_addr_i;
      end
      default: ;
    endcase
  end

  assign bus.ram_enable_o = ram_enable;
  assign bus.ram_write_o  = ram_write;
  assign bus.ram_addr_o   = ram_addr;
  assign bus.ram_wdata_o  = {SET_COUNT{bus.refill_data_i}};

  // Read-in-flight flag, hit way and SRAM command hold registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      set_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
    end else begin
      inflight_q <= lookup_fire;
      if (lookup_fire) set_q <= bus.lookup_set_i;
      if (refill_fire || lookup_fire) begin
        addr_q  <= ram_addr;
        write_q <= ram_write;
      end
    end
  end

  assign rd_line = bus.ram_rdata_i[set_q*LINE_WIDTH +: LINE_WIDTH];

  snitch_icache_data_rsp_fifo #(
    .WIDTH (LINE_WIDTH)
  ) i_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (rd_line),
    .pop_i       (bus.rsp_ready_i),
    .valid_o     (bus.rsp_valid_o),
    .data_o      (bus.rsp_data_o),
    .count_o     (fifo_count)
  );

`ifdef SNITCH_ICACHE_DATA_CTRL_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starve_q;

  assign guard_fire = (starve_q == StarveW'(STARVE_LIMIT));

  // Count refill wins over a lookup that could have issued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (lookup_fire || guard_fire) begin
      starve_q <= '0;
    end else if (refill_fire && bus.lookup_valid_i && credit_ok) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  logic                   lk_stall_q;
  logic [COUNT_ALIGN-1:0] lk_addr_q;
  logic [SET_ALIGN-1:0]   lk_set_q;
  logic                   rf_stall_q;
  logic [COUNT_ALIGN-1:0] rf_addr_q;
  logic [SET_ALIGN-1:0]   rf_set_q;
  logic [LINE_WIDTH-1:0]  rf_data_q;

  // Stalled requests must keep their payload until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lk_stall_q <= 1'b0;
      lk_addr_q  <= '0;
      lk_set_q   <= '0;
      rf_stall_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_set_q   <= '0;
      rf_data_q  <= '0;
    end else begin
      if (lk_stall_q && bus.lookup_valid_i) begin
        assert (bus.lookup_addr_i == lk_addr_q);
        assert (bus.lookup_set_i == lk_set_q);
      end
      if (rf_stall_q && bus.refill_valid_i) begin
        assert (bus.refill_addr_i == rf_addr_q);
        assert (bus.refill_set_i == rf_set_q);
        assert (bus.refill_data_i == rf_data_q);
      end
      lk_stall_q <= bus.lookup_valid_i && !lookup_ready;
      lk_addr_q  <= bus.lookup_addr_i;
      lk_set_q   <= bus.lookup_set_i;
      rf_stall_q <= bus.refill_valid_i && !refill_ready;
      rf_addr_q  <= bus.refill_addr_i;
      rf_set_q   <= bus.refill_set_i;
      rf_data_q  <= bus.refill_data_i;
    end
  end

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Directed bench for the icache data controller with a read-first
// SRAM model; exercises arbitration, credits, buffering and starvation.
module tb_snitch_icache_data_ctrl;
  import snitch_icache_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  snitch_icache_data_ctrl_if #(
    .SET_COUNT  (2),
    .LINE_WIDTH (128),
    .LINE_COUNT (128)
  ) bus ();

  snitch_icache_data_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_line_t      mem [2][128];
  logic [255:0]    rdata;

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (bus.ram_enable_o[w]) begin
        if (bus.ram_write_o)
          mem[w][bus.ram_addr_o] <= bus.ram_wdata_o[w*128 +: 128];
        else
          rdata[w*128 +: 128] <= mem[w][bus.ram_addr_o];
      end
    end
  end

  assign bus.ram_rdata_i = rdata;

  data_addr_t lk_addr [16];
  data_set_t  lk_set  [16];
  data_line_t lk_exp  [16];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refill(input data_addr_t a, input data_set_t s,
                        input data_line_t d);
    bus.refill_valid_i = 1'b1;
    bus.refill_addr_i  = a;
    bus.refill_set_i   = s;
    bus.refill_data_i  = d;
    #2;
    chk("refill_ready", bus.refill_ready_o, 1);
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
  endtask

  task automatic run_lk(input int n, input int hold,
                        output int acc_hold, output int iters);
    int li;
    int ri;
    int cyc;
    li = 0;
    ri = 0;
    cyc = 0;
    acc_hold = 0;
    while (ri < n && cyc < 100) begin
      bus.rsp_ready_i    = (cyc >= hold);
      bus.lookup_valid_i = (li < n);
      if (li < n) begin
        bus.lookup_addr_i = lk_addr[li];
        bus.lookup_set_i  = lk_set[li];
      end
      #2;
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        chk($sformatf("rsp_data[%0d]", ri), bus.rsp_data_o, lk_exp[ri]);
        ri++;
      end
      if (bus.lookup_valid_i && bus.lookup_ready_o) begin
        li++;
        if (cyc < hold) acc_hold++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.lookup_valid_i = 1'b0;
    bus.rsp_ready_i    = 1'b1;
    iters = cyc;
    chk("rsp_count", 128'(ri), 128'(n));
  endtask

  initial begin
    int acc;
    int it;
    int first;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.lookup_valid_i = 1'b0;
    bus.lookup_addr_i  = '0;
    bus.lookup_set_i   = '0;
    bus.rsp_ready_i    = 1'b1;
    bus.refill_valid_i = 1'b0;
    bus.refill_addr_i  = '0;
    bus.refill_set_i   = '0;
    bus.refill_data_i  = '0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_enable", bus.ram_enable_o, 0);
    chk("rst_write", bus.ram_write_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("idle_enable", bus.ram_enable_o, 0);
      chk("idle_rsp_valid", bus.rsp_valid_o, 0);
      @(negedge clk);
    end

    // refill then lookup of line 0x05 way 1
    bus.refill_valid_i = 1'b1;
    bus.refill_addr_i  = 7'h05;
    bus.refill_set_i   = 1'b1;
    bus.refill_data_i  = {16{8'hA5}};
    #2;
    chk("rf_ready", bus.refill_ready_o, 1);
    chk("rf_enable", bus.ram_enable_o, 2'b10);
    chk("rf_write", bus.ram_write_o, 1);
    chk("rf_addr", bus.ram_addr_o, 7'h05);
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    bus.lookup_valid_i = 1'b1;
    bus.lookup_addr_i  = 7'h05;
    bus.lookup_set_i   = 1'b1;
    #2;
    chk("lk_ready", bus.lookup_ready_o, 1);
    chk("lk_enable", bus.ram_enable_o, 2'b10);
    chk("lk_write", bus.ram_write_o, 0);
    @(negedge clk);
    bus.lookup_valid_i = 1'b0;
    #2;
    chk("lk_rsp_valid", bus.rsp_valid_o, 1);
    chk("lk_rsp_data", bus.rsp_data_o, {16{8'hA5}});
    @(negedge clk);
    #2;
    chk("hold_enable", bus.ram_enable_o, 0);
    chk("hold_write", bus.ram_write_o, 0);
    chk("hold_addr", bus.ram_addr_o, 7'h05);
    chk("hold_rsp_valid", bus.rsp_valid_o, 0);
    @(negedge clk);

    // simultaneous refill and lookup to line 0x10 way 0
    bus.refill_valid_i = 1'b1;
    bus.refill_addr_i  = 7'h10;
    bus.refill_set_i   = 1'b0;
    bus.refill_data_i  = {16{8'h11}};
    bus.lookup_valid_i = 1'b1;
    bus.lookup_addr_i  = 7'h10;
    bus.lookup_set_i   = 1'b0;
    #2;
    chk("sim_rf_ready", bus.refill_ready_o, 1);
    chk("sim_lk_ready", bus.lookup_ready_o, 0);
    chk("sim_enable", bus.ram_enable_o, 2'b01);
    chk("sim_write", bus.ram_write_o, 1);
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    #2;
    chk("sim_lk_ready2", bus.lookup_ready_o, 1);
    chk("sim_write2", bus.ram_write_o, 0);
    @(negedge clk);
    // refill the same line right after the read: read sees old line
    bus.lookup_valid_i = 1'b0;
    bus.refill_valid_i = 1'b1;
    bus.refill_data_i  = {16{8'h22}};
    #2;
    chk("haz_rsp_valid", bus.rsp_valid_o, 1);
    chk("haz_rsp_data", bus.rsp_data_o, {16{8'h11}});
    chk("haz_rf_ready", bus.refill_ready_o, 1);
    @(negedge clk);
    bus.refill_valid_i = 1'b0;
    lk_addr[0] = 7'h10;
    lk_set[0]  = 1'b0;
    lk_exp[0]  = {16{8'h22}};
    run_lk(1, 0, acc, it);
    chk("haz_iters", 128'(it), 128'(2));

    // backpressure: only two reads issue while the consumer stalls
    for (int i = 0; i < 4; i++) begin
      lk_addr[i] = data_addr_t'(8'h20 + i);
      lk_set[i]  = data_set_t'(i % 2);
      lk_exp[i]  = {4{32'hBEEF_0000 | i}};
      refill(lk_addr[i], lk_set[i], lk_exp[i]);
    end
    run_lk(4, 5, acc, it);
    chk("bp_accepted", 128'(acc), 128'(2));

    // streaming 16 back-to-back lookups
    for (int i = 0; i < 16; i++) begin
      lk_addr[i] = data_addr_t'(8'h40 + i);
      lk_set[i]  = data_set_t'(i % 2);
      lk_exp[i]  = {4{32'h1234_0000 + i}};
      refill(lk_addr[i], lk_set[i], lk_exp[i]);
    end
    run_lk(16, 0, acc, it);
    chk("stream_iters", 128'(it), 128'(17));

    // reset while a line is buffered drops it
    bus.rsp_ready_i    = 1'b0;
    bus.lookup_valid_i = 1'b1;
    bus.lookup_addr_i  = 7'h40;
    bus.lookup_set_i   = 1'b0;
    @(negedge clk);
    bus.lookup_valid_i = 1'b0;
    #2;
    chk("mid_rsp_valid", bus.rsp_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("mid_rst_write", bus.ram_write_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    #2;
    chk("post_rst_rsp_valid", bus.rsp_valid_o, 0);
    @(negedge clk);

    // refill held high against a pending lookup
    bus.refill_valid_i = 1'b1;
    bus.refill_addr_i  = 7'h7F;
    bus.refill_set_i   = 1'b0;
    bus.refill_data_i  = {16{8'h77}};
    bus.lookup_valid_i = 1'b1;
    bus.lookup_addr_i  = 7'h40;
    bus.lookup_set_i   = 1'b0;
    first = 0;
    for (int c = 1; c <= 8; c++) begin
      #2;
      if (first == 0 && bus.lookup_ready_o) first = c;
      @(negedge clk);
      if (first != 0) bus.lookup_valid_i = 1'b0;
    end
    bus.refill_valid_i = 1'b0;
    bus.lookup_valid_i = 1'b0;
`ifdef SNITCH_ICACHE_DATA_CTRL_STARVE_GUARD_EN
    chk("starve_accept_cycle", 128'(first), 128'(5));
`else
    chk("starve_accept_cycle", 128'(first), 128'(0));
`endif
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
